// File: rtl/tdp_ram_pkg.sv
// rtl/tdp_ram_pkg.sv - shared constants, FSM encoding and lane-merge helper for tdp_ram_be
package tdp_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MAX_DW    = 256;
  localparam int MAX_LANES = MAX_DW / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_t;

  function automatic logic [MAX_DW-1:0] lane_merge(input logic [MAX_DW-1:0]    old_w,
                                                   input logic [MAX_DW-1:0]    new_w,
                                                   input logic [MAX_LANES-1:0] be);
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/tdp_ram_be_if.sv
// rtl/tdp_ram_be_if.sv - one RAM access port: request, write data and registered read response
interface tdp_ram_be_if #(
  parameter int data_width = 16,
  parameter int addr_width = 4
);
  localparam int lanes = data_width / 8;

  logic                  en;
  logic                  we;
  logic [lanes-1:0]      be;
  logic [addr_width-1:0] addr;
  logic [data_width-1:0] din;
  logic [data_width-1:0] dout;
  logic                  valid;

  modport master (output en, we, be, addr, din, input dout, valid);
  modport slave  (input en, we, be, addr, din, output dout, valid);

endinterface

// File: rtl/ram_clear_seq.sv
// rtl/ram_clear_seq.sv - post-reset zero-clear sequencer: walks every word once, then READY
module ram_clear_seq
  import tdp_ram_pkg::*;
#(
  parameter int addr_width = 4,
  parameter int depth      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [addr_width-1:0] clr_addr
);

  clr_state_t            state;
  clr_state_t            state_nxt;
  logic [addr_width-1:0] clr_ptr;
  logic                  last;

  assign last = (clr_ptr == addr_width'(depth - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_ptr <= last ? '0 : clr_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (last) state_nxt = ST_READY;
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    init_busy = (state == ST_CLEAR);
    clr_we    = (state == ST_CLEAR) && !rst;
    clr_addr  = clr_ptr;
  end

endmodule

// File: rtl/tdp_ram_be.sv
// rtl/tdp_ram_be.sv - true dual-port byte-enable RAM with registered reads and post-reset clear
module tdp_ram_be
  import tdp_ram_pkg::*;
#(
  parameter int data_width = 16,
  parameter int addr_width = 4,
  parameter int depth      = 16,
  parameter int rdw_mode   = RDW_READ_FIRST
) (
  input  logic         clk,
  input  logic         rst,
  output logic         init_busy,
  output logic         collision,
  tdp_ram_be_if.slave  port_a,
  tdp_ram_be_if.slave  port_b
);

  localparam int lanes = data_width / 8;
  typedef logic [data_width-1:0] word_t;

  function automatic word_t merge(input word_t o, input word_t n, input logic [lanes-1:0] be);
    return data_width'(lane_merge(MAX_DW'(o), MAX_DW'(n), MAX_LANES'(be)));
  endfunction

  word_t mem [depth];

  logic                  clr_we;
  logic [addr_width-1:0] clr_addr;

  ram_clear_seq #(
    .addr_width(addr_width),
    .depth     (depth)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .init_busy(init_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic                  acc_a, acc_b, in_a, in_b, wr_a, wr_b, both_wr;
  word_t                 old_a, old_b, new_a, new_b, final_a, final_b, rd_a, rd_b;
  logic                  wr0_en;
  logic [addr_width-1:0] wr0_addr;
  word_t                 wr0_data;

  always_comb begin
    acc_a = !rst && !init_busy && port_a.en;
    acc_b = !rst && !init_busy && port_b.en;
    in_a  = 32'(port_a.addr) < 32'(depth);
    in_b  = 32'(port_b.addr) < 32'(depth);
    old_a = in_a ? mem[port_a.addr] : '0;
    old_b = in_b ? mem[port_b.addr] : '0;
    wr_a  = acc_a && port_a.we && in_a;
    wr_b  = acc_b && port_b.we && in_b;
    both_wr = wr_a && wr_b && (port_a.addr == port_b.addr);
    new_a = merge(old_a, port_a.din, port_a.be);
    new_b = merge(old_b, port_b.din, port_b.be);
    // On a shared write A's lanes are laid over B's, so A wins overlapping lanes.
    final_a = both_wr ? merge(new_b, port_a.din, port_a.be) : new_a;
    final_b = both_wr ? final_a : new_b;
    rd_a = (rdw_mode == RDW_WRITE_FIRST && wr_a) ? final_a : old_a;
    rd_b = (rdw_mode == RDW_WRITE_FIRST && wr_b) ? final_b : old_b;
    // The clear sequence borrows port A's write path; port A is idle then anyway.
    wr0_en   = clr_we || wr_a;
    wr0_addr = clr_we ? clr_addr : port_a.addr;
    wr0_data = clr_we ? '0 : final_a;
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr0_addr] <= wr0_data;
    if (wr_b && !both_wr) mem[port_b.addr] <= final_b;
    if (rst) begin
      port_a.dout  <= '0;
      port_b.dout  <= '0;
      port_a.valid <= 1'b0;
      port_b.valid <= 1'b0;
      collision    <= 1'b0;
    end else begin
      port_a.valid <= acc_a;
      port_b.valid <= acc_b;
      if (acc_a) port_a.dout <= rd_a;
      if (acc_b) port_b.dout <= rd_b;
      collision <= both_wr && |(port_a.be & port_b.be);
    end
  end

endmodule

// File: tb/tb_tdp_ram_be.sv
// tb/tb_tdp_ram_be.sv - scoreboard bench: READ_FIRST and WRITE_FIRST instances on shared stimulus
module tb_tdp_ram_be;
  import tdp_ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdp_ram_be_if #(.data_width(16), .addr_width(4)) a0 ();
  tdp_ram_be_if #(.data_width(16), .addr_width(4)) b0 ();
  tdp_ram_be_if #(.data_width(16), .addr_width(5)) a1 ();
  tdp_ram_be_if #(.data_width(16), .addr_width(5)) b1 ();
  logic ib0, ib1, col0, col1;

  // dut1 has a 5-bit address over 16 words, so addresses 16..31 are out of range.
  tdp_ram_be #(.data_width(16), .addr_width(4), .depth(16), .rdw_mode(RDW_READ_FIRST)) dut0 (
    .clk(clk), .rst(rst), .init_busy(ib0), .collision(col0), .port_a(a0), .port_b(b0));
  tdp_ram_be #(.data_width(16), .addr_width(5), .depth(16), .rdw_mode(RDW_WRITE_FIRST)) dut1 (
    .clk(clk), .rst(rst), .init_busy(ib1), .collision(col1), .port_a(a1), .port_b(b1));

  typedef struct packed {
    logic        en;
    logic        we;
    logic [1:0]  be;
    logic [4:0]  addr;
    logic [15:0] din;
  } req_t;
  typedef struct packed { logic [15:0] e0; logic [15:0] e1; } exp_t;
  typedef struct packed { logic c0; logic c1; } col_t;

  exp_t        qa[$];
  exp_t        qb[$];
  col_t        qc[$];
  logic [15:0] m [2][16];
  int          checks = 0;
  int          errors = 0;
  int          busy_left = 0;
  bit          started = 0;

  function automatic req_t rq(input logic en, input logic we, input logic [1:0] be,
                              input logic [4:0] addr, input logic [15:0] din);
    req_t r;
    r.en = en; r.we = we; r.be = be; r.addr = addr; r.din = din;
    return r;
  endfunction

  localparam req_t IDLE = '0;

  task automatic step(input logic r, input req_t a, input req_t b);
    logic [4:0]  ia, ix;
    logic        ina, inb, wa, wb;
    logic [15:0] oa, ob;
    exp_t        ea, eb;
    col_t        c;
    rst = r;
    a0.en = a.en; a0.we = a.we; a0.be = a.be; a0.addr = a.addr[3:0]; a0.din = a.din;
    a1.en = a.en; a1.we = a.we; a1.be = a.be; a1.addr = a.addr;      a1.din = a.din;
    b0.en = b.en; b0.we = b.we; b0.be = b.be; b0.addr = b.addr[3:0]; b0.din = b.din;
    b1.en = b.en; b1.we = b.we; b1.be = b.be; b1.addr = b.addr;      b1.din = b.din;
    if (started) begin
      checks++;
      if (ib0 !== (busy_left > 0) || ib1 !== (busy_left > 0)) begin
        errors++;
        $display("FAIL init_busy got %b/%b expected %0d", ib0, ib1, busy_left > 0);
      end
    end
    if (r) begin
      busy_left = 16;
      for (int k = 0; k < 2; k++) for (int i = 0; i < 16; i++) m[k][i] = 16'h0000;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      ea = '0; eb = '0; c = '0;
      for (int k = 0; k < 2; k++) begin
        ia  = (k == 0) ? {1'b0, a.addr[3:0]} : a.addr;
        ix  = (k == 0) ? {1'b0, b.addr[3:0]} : b.addr;
        ina = ia < 16;
        inb = ix < 16;
        oa  = (a.en && ina) ? m[k][ia[3:0]] : 16'h0000;
        ob  = (b.en && inb) ? m[k][ix[3:0]] : 16'h0000;
        wa  = a.en && a.we && ina;
        wb  = b.en && b.we && inb;
        // B is applied first so A's bytes land on top where both enable a lane.
        if (wb) for (int l = 0; l < 2; l++) if (b.be[l]) m[k][ix[3:0]][8*l +: 8] = b.din[8*l +: 8];
        if (wa) for (int l = 0; l < 2; l++) if (a.be[l]) m[k][ia[3:0]][8*l +: 8] = a.din[8*l +: 8];
        if (k == 1) begin
          ea.e1 = (a.we && ina) ? m[1][ia[3:0]] : oa;
          eb.e1 = (b.we && inb) ? m[1][ix[3:0]] : ob;
          c.c1  = wa && wb && (ia == ix) && ((a.be & b.be) != 2'b00);
        end else begin
          ea.e0 = oa;
          eb.e0 = ob;
          c.c0  = wa && wb && (ia == ix) && ((a.be & b.be) != 2'b00);
        end
      end
      if (a.en) qa.push_back(ea);
      if (b.en) qb.push_back(eb);
      if (a.en || b.en) qc.push_back(c);
    end
    @(posedge clk);
    #1;
    started = 1;
  endtask

  task automatic check_clear_len(input string name);
    int cnt;
    cnt = 0;
    while (ib0 === 1'b1 && cnt < 40) begin
      step(0, rq(1, 0, 2'b00, 5'd5, 16'h0), rq(1, 0, 2'b00, 5'd5, 16'h0));
      cnt++;
    end
    checks++;
    if (cnt != 16) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d expected 16", name, cnt);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    col_t c;
    if (a0.valid !== a1.valid || b0.valid !== b1.valid) begin
      checks++; errors++;
      $display("FAIL valid_match a %b/%b b %b/%b", a0.valid, a1.valid, b0.valid, b1.valid);
    end
    if (a0.valid === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++; $display("FAIL valid_a got unexpected valid expected none");
      end else begin
        e = qa.pop_front();
        if (a0.dout !== e.e0 || a1.dout !== e.e1) begin
          errors++;
          $display("FAIL dout_a got %h/%h expected %h/%h", a0.dout, a1.dout, e.e0, e.e1);
        end
      end
    end
    if (b0.valid === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++; $display("FAIL valid_b got unexpected valid expected none");
      end else begin
        e = qb.pop_front();
        if (b0.dout !== e.e0 || b1.dout !== e.e1) begin
          errors++;
          $display("FAIL dout_b got %h/%h expected %h/%h", b0.dout, b1.dout, e.e0, e.e1);
        end
      end
    end
    if (a0.valid === 1'b1 || b0.valid === 1'b1) begin
      checks++;
      if (qc.size() == 0) begin
        errors++; $display("FAIL collision_q got access with no expectation expected one");
      end else begin
        c = qc.pop_front();
        if (col0 !== c.c0 || col1 !== c.c1) begin
          errors++;
          $display("FAIL collision got %b/%b expected %b/%b", col0, col1, c.c0, c.c1);
        end
      end
    end else if (col0 === 1'b1 || col1 === 1'b1) begin
      checks++; errors++;
      $display("FAIL collision_idle got %b/%b expected 0/0", col0, col1);
    end
  end

  initial begin
    req_t ra, rb;
    step(1, IDLE, IDLE);
    step(1, IDLE, IDLE);
    repeat (16) step(0, IDLE, IDLE);

    // Preloaded word must be zeroed by the clear that follows a one-cycle reset.
    step(0, rq(1, 1, 2'b11, 5'd5, 16'hBEEF), IDLE);
    step(0, rq(1, 0, 2'b00, 5'd5, 16'h0), IDLE);
    step(1, IDLE, IDLE);
    check_clear_len("reset_clear");
    step(0, rq(1, 0, 2'b00, 5'd5, 16'h0), IDLE);

    step(0, rq(1, 1, 2'b11, 5'd3, 16'h1234), IDLE);
    step(0, rq(1, 1, 2'b10, 5'd3, 16'hAB00), IDLE);
    step(0, IDLE, rq(1, 0, 2'b00, 5'd3, 16'h0));

    step(0, rq(1, 1, 2'b11, 5'd7, 16'h1111), IDLE);
    step(0, rq(1, 1, 2'b11, 5'd7, 16'h2222), IDLE);
    step(0, rq(1, 0, 2'b00, 5'd7, 16'h0), IDLE);

    step(0, rq(1, 1, 2'b01, 5'd9, 16'hAAAA), rq(1, 1, 2'b11, 5'd9, 16'hBBBB));
    step(0, rq(1, 0, 2'b00, 5'd9, 16'h0), IDLE);
    step(0, rq(1, 1, 2'b01, 5'd9, 16'h1357), rq(1, 1, 2'b10, 5'd9, 16'h2468));
    step(0, IDLE, rq(1, 0, 2'b00, 5'd9, 16'h0));

    step(0, rq(1, 1, 2'b11, 5'd2, 16'h0F0F), IDLE);
    step(0, rq(1, 1, 2'b11, 5'd2, 16'hF0F0), rq(1, 0, 2'b00, 5'd2, 16'h0));
    step(0, IDLE, rq(1, 0, 2'b00, 5'd2, 16'h0));

    step(0, rq(1, 1, 2'b11, 5'd20, 16'h5A5A), rq(1, 0, 2'b00, 5'd20, 16'h0));
    step(0, rq(1, 0, 2'b00, 5'd20, 16'h0), rq(1, 1, 2'b00, 5'd4, 16'hFFFF));

    for (int n = 0; n < 400; n++) begin
      ra = rq($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 31)), 16'($urandom));
      rb = rq($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 31)), 16'($urandom));
      if ($urandom_range(0, 2) == 0) rb.addr = ra.addr;
      step(0, ra, rb);
    end

    step(1, IDLE, IDLE);
    repeat (8) step(0, IDLE, IDLE);
    step(1, IDLE, IDLE);
    check_clear_len("mid_clear_reset");
    for (int n = 0; n < 40; n++) begin
      ra = rq(1'b1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 15)), 16'($urandom));
      rb = rq(1'b1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), ra.addr, 16'($urandom));
      step(0, ra, rb);
    end
    repeat (3) step(0, IDLE, IDLE);

    checks++;
    if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
      errors++;
      $display("FAIL drain pending a=%0d b=%0d c=%0d expected 0", qa.size(), qb.size(), qc.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
